// File: rtl/bsg_link_pkg.sv
// Constants and types shared by the off-chip link output and input stages.
// A link word is four 16-bit beats, each beat carrying two 8-bit channels.
package bsg_link_pkg;
   localparam int BEATS_PER_WORD = 4;
   localparam int CHANNEL_W      = 8;
   localparam int WORD_W         = 64;
   localparam int BEAT_W         = 2 * CHANNEL_W;
   localparam int BEAT_IDX_W     = $clog2(BEATS_PER_WORD);

   typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

   localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS_PER_WORD - 1);
endpackage

// File: rtl/bsg_link_word_fifo.sv
// One-read/one-write flop FIFO holding reassembled link words.
// A write while full is accepted only when a read retires the head in the same cycle.
module bsg_link_word_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             wr_fire, rd_fire;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign rd_fire = rd_en_i & ~empty_o;
   assign wr_fire = wr_en_i & (~full_o | rd_fire);

   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is deliberately left out of reset; the pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end
endmodule

// File: rtl/bsg_downstream_in.sv
// Link receive stage: assembles 16-bit beats into 64-bit words, buffers them
// for the core and returns one credit token per word the core consumes.
import bsg_link_pkg::*;

module bsg_downstream_in #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 io_valid_in,
   input  logic [CHANNEL_W-1:0] io_data_in_ch0,
   input  logic [CHANNEL_W-1:0] io_data_in_ch1,
   output logic                 io_token_out,
   output logic                 core_valid_out,
   output logic [WORD_W-1:0]    core_data_out,
   input  logic                 core_ready_in,
   output logic                 overflow_o
);
   localparam int PART_W = WORD_W - BEAT_W;

   beat_idx_t         beat_q, beat_d;
   logic [PART_W-1:0] part_q, part_d;
   logic [BEAT_W-1:0] beat_data;
   logic [WORD_W-1:0] full_word;
   logic              word_done;
   logic              fifo_full, fifo_empty;
   logic              deq;
   logic              token_q;
   logic              overflow_q;

   assign beat_data = {io_data_in_ch1, io_data_in_ch0};
   assign word_done = io_valid_in & (beat_q == LAST_BEAT);
   assign full_word = {beat_data, part_q};

   always_comb begin
      beat_d = beat_q;
      part_d = part_q;
      if (io_valid_in) begin
         beat_d = beat_q + beat_idx_t'(1);
         // The last beat goes straight into the FIFO, so only earlier beats are held.
         if (beat_q != LAST_BEAT)
            part_d[int'(beat_q)*BEAT_W +: BEAT_W] = beat_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_q     <= '0;
         part_q     <= '0;
         token_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         beat_q  <= beat_d;
         part_q  <= part_d;
         token_q <= deq;
         if (word_done & fifo_full & ~deq) overflow_q <= 1'b1;
      end
   end

   bsg_link_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (word_done),
      .wr_data_i (full_word),
      .rd_en_i   (deq),
      .rd_data_o (core_data_out),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign core_valid_out = ~fifo_empty;
   assign deq            = core_valid_out & core_ready_in;
   assign io_token_out   = token_q;
   assign overflow_o     = overflow_q;
endmodule
